// File: rtl/nanov_spi_arbiter_pkg.sv
// Shared types and constants for the nanoV SPI bus arbiter.
package nanov_spi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_AUX = 1;

  // One counter serves both the CS gap and the hold timer, so size it for the larger.
  function automatic int cnt_width(input int gap, input int hold);
    int m;
    m = (gap > hold) ? gap : hold;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/nanov_spi_arbiter.sv
// Two-requester SPI pad arbiter with chip-select gap and advisory yield.
// Define NANOV_SPI_ARB_RR_EN for round-robin tie-break; otherwise requester 0 wins ties.
module nanov_spi_arbiter
  import nanov_spi_arbiter_pkg::*;
#(
  parameter int CS_GAP   = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       yield0,
  output logic       yield1,
  input  logic       sel0,
  input  logic       sel1,
  input  logic       out0,
  input  logic       out1,
  input  logic       clk_en0,
  input  logic       clk_en1,
  output logic       in0,
  output logic       in1,
  output logic       spi_select,
  output logic       spi_out,
  output logic       spi_clk_enable,
  input  logic       spi_data_in,
  output arb_state_e state_dbg
);

  localparam int              CNT_W    = cnt_width(CS_GAP, MAX_HOLD);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             own_req;
  logic             tie_pick1;

`ifdef NANOV_SPI_ARB_RR_EN
  logic last_q;

  // Remembers who was granted last so a tie goes to the other side.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= 1'b1;
    end else if (state_q == ST_IDLE && state_d == ST_OWN0) begin
      last_q <= 1'b0;
    end else if (state_q == ST_IDLE && state_d == ST_OWN1) begin
      last_q <= 1'b1;
    end
  end

  assign tie_pick1 = ~last_q;
`else
  assign tie_pick1 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign own_req = (state_q == ST_OWN0) ? req0 : req1;

  // In OWNx the counter is the hold timer; in GAP it counts down the CS-high gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (req0 && req1) begin
          state_d = tie_pick1 ? ST_OWN1 : ST_OWN0;
        end else if (req0) begin
          state_d = ST_OWN0;
        end else if (req1) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req) begin
          state_d = (CS_GAP == 0) ? ST_IDLE : ST_GAP;
          cnt_d   = GAP_LD;
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pads follow the owner combinationally; the bus is parked deselected otherwise.
  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    in0            = 1'b0;
    in1            = 1'b0;
    spi_select     = 1'b1;
    spi_out        = 1'b0;
    spi_clk_enable = 1'b0;
    case (state_q)
      ST_OWN0: begin
        gnt0           = 1'b1;
        spi_select     = sel0;
        spi_out        = out0;
        spi_clk_enable = clk_en0;
        in0            = spi_data_in;
      end
      ST_OWN1: begin
        gnt1           = 1'b1;
        spi_select     = sel1;
        spi_out        = out1;
        spi_clk_enable = clk_en1;
        in1            = spi_data_in;
      end
      default: ;
    endcase
    yield0 = gnt0 && req1 && (cnt_q == HOLD_MAX);
    yield1 = gnt1 && req0 && (cnt_q == HOLD_MAX);
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_nanov_spi_arbiter.sv
// Self-checking bench for nanov_spi_arbiter: main instance CS_GAP=2/MAX_HOLD=4, second instance CS_GAP=0.
module tb_nanov_spi_arbiter;
  import nanov_spi_arbiter_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic req0 = 0, req1 = 0, sel0 = 1, sel1 = 1, out0 = 0, out1 = 0;
  logic clk_en0 = 0, clk_en1 = 0, spi_data_in = 0;

  logic gnt0, gnt1, yield0, yield1, in0, in1, spi_select, spi_out, spi_clk_enable;
  arb_state_e state_dbg;
  logic gnt0_b, gnt1_b, yield0_b, yield1_b, in0_b, in1_b, spi_select_b, spi_out_b, spi_clk_enable_b;
  arb_state_e state_dbg_b;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp;

  nanov_spi_arbiter #(.CS_GAP(2), .MAX_HOLD(4)) dut (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .yield0(yield0), .yield1(yield1), .sel0(sel0), .sel1(sel1), .out0(out0), .out1(out1),
    .clk_en0(clk_en0), .clk_en1(clk_en1), .in0(in0), .in1(in1), .spi_select(spi_select),
    .spi_out(spi_out), .spi_clk_enable(spi_clk_enable), .spi_data_in(spi_data_in),
    .state_dbg(state_dbg)
  );

  nanov_spi_arbiter #(.CS_GAP(0), .MAX_HOLD(64)) dut_b (
    .clk(clk), .rstn(rstn), .req0(req0), .req1(req1), .gnt0(gnt0_b), .gnt1(gnt1_b),
    .yield0(yield0_b), .yield1(yield1_b), .sel0(sel0), .sel1(sel1), .out0(out0), .out1(out1),
    .clk_en0(clk_en0), .clk_en1(clk_en1), .in0(in0_b), .in1(in1_b), .spi_select(spi_select_b),
    .spi_out(spi_out_b), .spi_clk_enable(spi_clk_enable_b), .spi_data_in(spi_data_in),
    .state_dbg(state_dbg_b)
  );

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rstn = 0; req0 = 0; req1 = 0; sel0 = 1; sel1 = 1; out0 = 0; out1 = 0;
    clk_en0 = 0; clk_en1 = 0; spi_data_in = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1;
  endtask

  // Returns the owner id seen on the main DUT (3 = none within budget) and edges taken.
  task automatic wait_grant(output logic [1:0] id, output int lat);
    id = 2'd3;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (gnt0 || gnt1) begin
        id = gnt0 ? 2'd0 : 2'd1;
        lat = k;
        return;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 0;
    spi_data_in = 1;
    #1;
    checks++;
    if ({gnt0, gnt1, yield0, yield1} !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt_yield got %b want 0000", {gnt0, gnt1, yield0, yield1});
    end
    checks++;
    if ({in0, in1} !== 2'b00) begin
      errors++; $display("FAIL reset_in got %b want 00", {in0, in1});
    end
    checks++;
    if ({spi_select, spi_out, spi_clk_enable} !== 3'b100) begin
      errors++; $display("FAIL reset_pads got %b want 100", {spi_select, spi_out, spi_clk_enable});
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [1:0] id;
    int lat;
    logic d;
    do_reset();
    req0 = 1;
    exp_q.push_back(2'd0);
    wait_grant(id, lat);
    exp = exp_q.pop_front();
    checks++;
    if (id !== exp || lat != 1) begin
      errors++; $display("FAIL single_grant got id %0d lat %0d want id %0d lat 1", id, lat, exp);
    end
    sel0 = 0; out0 = 1; clk_en0 = 1; sel1 = 1; out1 = 0; clk_en1 = 0;
    #1;
    checks++;
    if ({spi_select, spi_out, spi_clk_enable} !== 3'b011) begin
      errors++; $display("FAIL single_pads got %b want 011", {spi_select, spi_out, spi_clk_enable});
    end
    for (int i = 0; i < 6; i++) begin
      d = 1'($urandom_range(0, 1));
      spi_data_in = d;
      out0 = ~d;
      out1 = d;
      #1;
      checks++;
      if (in0 !== d || in1 !== 1'b0 || spi_out !== ~d) begin
        errors++;
        $display("FAIL single_miso got in0 %b in1 %b mosi %b want %b 0 %b", in0, in1, spi_out, d, ~d);
      end
      @(negedge clk);
    end
    req0 = 0; sel0 = 1; out0 = 0; clk_en0 = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_handover();
    logic [1:0] id;
    int lat;
    int hi_cnt;
    int k_gnt;
    do_reset();
    req0 = 1;
    exp_q.push_back(2'd0);
    wait_grant(id, lat);
    exp = exp_q.pop_front();
    checks++;
    if (id !== exp) begin
      errors++; $display("FAIL handover_first got %0d want %0d", id, exp);
    end
    sel0 = 0; req1 = 1;
    @(posedge clk);
    @(negedge clk);
    req0 = 0; sel0 = 1; sel1 = 0;
    exp_q.push_back(2'd1);
    hi_cnt = 0;
    k_gnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) begin
        checks++;
        if (gnt0 !== 1'b0 || state_dbg !== ST_GAP) begin
          errors++; $display("FAIL handover_drop got gnt0 %b state %0d want 0 %0d", gnt0, state_dbg, ST_GAP);
        end
      end
      if (gnt0 || gnt1) begin
        k_gnt = k;
        id = gnt0 ? 2'd0 : 2'd1;
        break;
      end
      if (spi_select) hi_cnt++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (k_gnt != 4 || id !== exp) begin
      errors++; $display("FAIL handover_latency got edges %0d id %0d want 4 id %0d", k_gnt, id, exp);
    end
    checks++;
    if (hi_cnt < 3) begin
      errors++; $display("FAIL handover_cs_gap got %0d high cycles want >=3", hi_cnt);
    end
    #1;
    checks++;
    if (spi_select !== 1'b0) begin
      errors++; $display("FAIL handover_new_owner_sel got %b want 0", spi_select);
    end
    req1 = 0; sel1 = 1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_tie_break();
    logic [1:0] id;
    int lat;
    do_reset();
    for (int r = 0; r < 3; r++) begin
      req0 = 1; req1 = 1;
`ifdef NANOV_SPI_ARB_RR_EN
      exp_q.push_back((r % 2 == 0) ? 2'd0 : 2'd1);
`else
      exp_q.push_back(2'd0);
`endif
      wait_grant(id, lat);
      exp = exp_q.pop_front();
      checks++;
      if (id !== exp || lat != 1) begin
        errors++; $display("FAIL tie_break_%0d got id %0d lat %0d want id %0d lat 1", r, id, lat, exp);
      end
      req0 = 0; req1 = 0;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_yield();
    logic [1:0] id;
    int lat;
    int k_y;
    bit y1_seen;
    do_reset();
    req0 = 1;
    wait_grant(id, lat);
    req1 = 1;
    #1;
    checks++;
    if (id !== 2'd0 || yield0 !== 1'b0) begin
      errors++; $display("FAIL yield_early got id %0d yield0 %b want 0 0", id, yield0);
    end
    k_y = 0;
    y1_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (yield1) y1_seen = 1;
      if (yield0) begin
        k_y = k;
        break;
      end
    end
    checks++;
    if (k_y != 4) begin
      errors++; $display("FAIL yield_timing got %0d cycles want 4", k_y);
    end
    @(posedge clk);
    @(negedge clk);
    if (yield1) y1_seen = 1;
    checks++;
    if (yield0 !== 1'b1 || gnt0 !== 1'b1) begin
      errors++; $display("FAIL yield_saturate got yield0 %b gnt0 %b want 1 1", yield0, gnt0);
    end
    req0 = 0;
    @(posedge clk);
    @(negedge clk);
    if (yield1) y1_seen = 1;
    checks++;
    if (yield0 !== 1'b0 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL yield_clear got yield0 %b gnt0 %b want 0 0", yield0, gnt0);
    end
    checks++;
    if (y1_seen) begin
      errors++; $display("FAIL yield1_quiet got 1 want 0");
    end
    req1 = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_async_reset();
    logic [1:0] id;
    int lat;
    do_reset();
    req1 = 1; sel1 = 0;
    wait_grant(id, lat);
    checks++;
    if (id !== 2'd1 || spi_select !== 1'b0) begin
      errors++; $display("FAIL areset_setup got id %0d sel %b want 1 0", id, spi_select);
    end
    #2 rstn = 0;
    #1;
    checks++;
    if (spi_select !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL areset_async got sel %b gnt1 %b want 1 0", spi_select, gnt1);
    end
    do_reset();
  endtask

  task automatic test_gap_zero();
    int k_gnt;
    bit gap_seen;
    do_reset();
    req0 = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (gnt0_b !== 1'b1) begin
      errors++; $display("FAIL gap0_first got gnt0 %b want 1", gnt0_b);
    end
    req1 = 1;
    @(posedge clk);
    @(negedge clk);
    req0 = 0;
    exp_q.push_back(2'd1);
    k_gnt = 0;
    gap_seen = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (state_dbg_b == ST_GAP) gap_seen = 1;
      if (gnt1_b) begin
        k_gnt = k;
        break;
      end
    end
    exp = exp_q.pop_front();
    checks++;
    if (k_gnt != 2 || gnt1_b !== exp[0]) begin
      errors++; $display("FAIL gap0_latency got edges %0d gnt1 %b want 2 1", k_gnt, gnt1_b);
    end
    checks++;
    if (gap_seen) begin
      errors++; $display("FAIL gap0_no_gap got gap visited want none");
    end
    req1 = 0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_handover();
    test_tie_break();
    test_yield();
    test_async_reset();
    test_gap_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
